input_io_bank: RTL and testbench

- Parametrised, multi-channel successor of the single-bit input IO cell.
- Each channel takes a pad-to-fabric signal (A2F) and provides:
  - an N-stage synchroniser;
  - a consecutive-sample glitch filter;
  - a freeze (hold) control;
  - optional one-cycle rise/fall event pulses.
- Sits between the IO pads and fabric logic, wherever asynchronous or noisy inputs enter a clocked domain.
- A bypass mode keeps the old combinational buffer behaviour.

---
 rtl/input_io_bank_pkg.sv | 21 ++
 rtl/input_io_bank_if.sv | 25 ++
 rtl/input_io_bank_chan.sv | 97 +++++++++
 rtl/input_io_bank.sv | 57 +++++
 tb/tb_input_io_bank.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/input_io_bank_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_io_pkg
// Brief    : Shared mode constants, counter sizing and reset level for the
//            input IO bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package input_io_pkg;

    localparam string IO_MODE_BUFF = "in_buff";
    localparam string IO_MODE_REG  = "in_reg";

    // Every channel flop (sync chain, IQZ, edge pulses) clears to this level.
    localparam logic CHAN_RST_LVL = 1'b0;

    function automatic int cnt_width(input int filter_cnt);
        return $clog2(filter_cnt + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_io_bank_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_io_bank_if
// Brief    : Pad/fabric signal bundle of the input IO bank. RISE/FALL exist
//            only when INPUT_IO_BANK_EDGE_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface input_io_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A2F;
    logic [WIDTH-1:0] HOLD;
    logic [WIDTH-1:0] IQZ;
`ifdef INPUT_IO_BANK_EDGE_EN
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (output A2F, output HOLD, input IQZ, input RISE, input FALL);
    modport slave  (input A2F, input HOLD, output IQZ, output RISE, output FALL);
`else
    modport master (output A2F, output HOLD, input IQZ);
    modport slave  (input A2F, input HOLD, output IQZ);
`endif
endinterface
`default_nettype wire

// File: rtl/input_io_bank_chan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_io_chan
// Brief    : One input channel: N-stage synchroniser, consecutive-sample
//            glitch filter with hold, optional rise/fall pulses
//            (INPUT_IO_BANK_EDGE_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module input_io_chan
    import input_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CNT  = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_a2f,
    input  wire logic i_hold,
`ifdef INPUT_IO_BANK_EDGE_EN
    output logic      o_rise,
    output logic      o_fall,
`endif
    output logic      o_iqz
);

    localparam int            CW         = cnt_width(FILTER_CNT);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(FILTER_CNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sy;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_iqz;
    logic                   w_iqz_next;

    assign w_sy  = r_sync[SYNC_STAGES-1];
    assign o_iqz = r_iqz;

    // The synchroniser keeps running while the channel is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{CHAN_RST_LVL}};
        end else begin
            r_sync[0] <= i_a2f;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Any sample that agrees with IQZ restarts the run of differing samples.
    always_comb begin
        w_iqz_next = r_iqz;
        w_cnt_next = r_cnt;
        if (!i_hold) begin
            if (w_sy == r_iqz) begin
                w_cnt_next = '0;
            end else if (r_cnt == C_CNT_LAST) begin
                w_iqz_next = w_sy;
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iqz <= CHAN_RST_LVL;
            r_cnt <= '0;
        end else begin
            r_iqz <= w_iqz_next;
            r_cnt <= w_cnt_next;
        end
    end

`ifdef INPUT_IO_BANK_EDGE_EN
    logic r_rise;
    logic r_fall;

    assign o_rise = r_rise;
    assign o_fall = r_fall;

    // Reset clears the pulses directly, so a reset-forced 1->0 never flags FALL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= CHAN_RST_LVL;
            r_fall <= CHAN_RST_LVL;
        end else begin
            r_rise <= w_iqz_next & ~r_iqz;
            r_fall <= ~w_iqz_next & r_iqz;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/input_io_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_io_bank
// Brief    : Multi-channel input IO cell: filtered registered path or
//            combinational bypass. Edge pulses gated by INPUT_IO_BANK_EDGE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module input_io_bank
    import input_io_pkg::*;
#(
    parameter int    WIDTH       = 8,
    parameter string MODE        = "in_reg",
    parameter int    SYNC_STAGES = 2,
    parameter int    FILTER_CNT  = 3
) (
    input  wire logic        IQC,
    input  wire logic        QRT,
    input_io_bank_if.slave   io
);

    if (MODE == IO_MODE_BUFF) begin : g_buff
        assign io.IQZ = io.A2F;
`ifdef INPUT_IO_BANK_EDGE_EN
        assign io.RISE = '0;
        assign io.FALL = '0;
`endif
    end else begin : g_reg
        logic [WIDTH-1:0] w_iqz;
`ifdef INPUT_IO_BANK_EDGE_EN
        logic [WIDTH-1:0] w_rise;
        logic [WIDTH-1:0] w_fall;

        assign io.RISE = w_rise;
        assign io.FALL = w_fall;
`endif
        assign io.IQZ = w_iqz;

        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            input_io_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_CNT  (FILTER_CNT)
            ) u_chan (
                .clk    (IQC),
                .rst    (QRT),
                .i_a2f  (io.A2F[i]),
                .i_hold (io.HOLD[i]),
`ifdef INPUT_IO_BANK_EDGE_EN
                .o_rise (w_rise[i]),
                .o_fall (w_fall[i]),
`endif
                .o_iqz  (w_iqz[i])
            );
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_io_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_input_io_bank
// Brief    : Cycle-table bench for the registered bank plus a bypass instance.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_input_io_bank;

    logic clk = 1'b0;
    logic qrt = 1'b1;

    always #5 clk = ~clk;

    input_io_bank_if #(.WIDTH(4)) rif ();
    input_io_bank_if #(.WIDTH(4)) bif ();

    input_io_bank #(
        .WIDTH(4), .MODE("in_reg"), .SYNC_STAGES(2), .FILTER_CNT(3)
    ) dut (
        .IQC (clk),
        .QRT (qrt),
        .io  (rif.slave)
    );

    input_io_bank #(
        .WIDTH(4), .MODE("in_buff"), .SYNC_STAGES(2), .FILTER_CNT(3)
    ) dut_buff (
        .IQC (clk),
        .QRT (qrt),
        .io  (bif.slave)
    );

    typedef struct {
        int         n;
        logic [3:0] a2f;
        logic [3:0] hold;
        logic       qrt;
        logic [3:0] iqz;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input int n, input logic [3:0] a, input logic [3:0] h,
                                input logic q, input logic [3:0] z,
                                input logic [3:0] r, input logic [3:0] f);
        vec_t v;
        v.n = n; v.a2f = a; v.hold = h; v.qrt = q;
        v.iqz = z; v.rise = r; v.fall = f;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v_a;
        rif.A2F  = '0;
        rif.HOLD = '0;
        bif.A2F  = '0;
        bif.HOLD = '0;

        // Each row: expected state right after the edge that samples its inputs.
        //   n   A2F   HOLD  QRT  IQZ   RISE  FALL
        // Reset, then release with all channels high: IQZ at 4th edge after sampling.
        add(2, 4'hF, 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(4, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0);
        add(1, 4'hF, 4'h0, 0, 4'hF, 4'h0, 4'h0);
        // Reset forces IQZ low without a FALL pulse.
        add(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        // Two-cycle pulse on channel 1 is rejected.
        add(2, 4'h2, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(3, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        // Three-cycle pulse passes, IQZ[1] high for three cycles.
        add(3, 4'h2, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h2, 4'h2, 4'h0);
        add(2, 4'h0, 4'h0, 0, 4'h2, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h2);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        // Channel 2 held for 10 cycles, then 3 edges after release.
        add(10, 4'h4, 4'h4, 0, 4'h0, 4'h0, 4'h0);
        add(2, 4'h4, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 0, 4'h4, 4'h4, 4'h0);
        add(1, 4'h4, 4'h0, 0, 4'h4, 4'h0, 4'h0);
        // Channel 0 counts to 2, reset discards it; full latency afterwards.
        add(4, 4'h5, 4'h0, 0, 4'h4, 4'h0, 4'h0);
        add(1, 4'h5, 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(4, 4'h5, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h5, 4'h0, 0, 4'h5, 4'h5, 4'h0);
        add(1, 4'h5, 4'h0, 0, 4'h5, 4'h0, 4'h0);
        // Parallel channels rise together, then fall together.
        add(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(4, 4'hA, 4'h0, 0, 4'h0, 4'h0, 4'h0);
        add(1, 4'hA, 4'h0, 0, 4'hA, 4'hA, 4'h0);
        add(1, 4'hA, 4'h0, 0, 4'hA, 4'h0, 4'h0);
        add(4, 4'h0, 4'h0, 0, 4'hA, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'hA);
        add(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                @(negedge clk);
                rif.A2F  = tbl[i].a2f;
                rif.HOLD = tbl[i].hold;
                qrt      = tbl[i].qrt;
                @(posedge clk);
                #1;
                chk($sformatf("row%0d.%0d iqz", i, j), rif.IQZ, tbl[i].iqz);
`ifdef INPUT_IO_BANK_EDGE_EN
                chk($sformatf("row%0d.%0d rise", i, j), rif.RISE, tbl[i].rise);
                chk($sformatf("row%0d.%0d fall", i, j), rif.FALL, tbl[i].fall);
`endif
            end
        end

        // Bypass instance: IQZ follows A2F immediately, QRT/HOLD irrelevant.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v_a      = 4'($urandom);
            bif.A2F  = v_a;
            bif.HOLD = 4'($urandom);
            qrt      = 1'($urandom);
            #1;
            chk($sformatf("buff%0d comb", k), bif.IQZ, v_a);
            @(posedge clk);
            #1;
            chk($sformatf("buff%0d post-edge", k), bif.IQZ, v_a);
`ifdef INPUT_IO_BANK_EDGE_EN
            chk($sformatf("buff%0d rise", k), bif.RISE, 4'h0);
            chk($sformatf("buff%0d fall", k), bif.FALL, 4'h0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
